// File: rtl/k_and_s_decode_stage_pkg.sv
// K&S decode definitions: one-hot decoded instruction type, opcode constants
// and the opcode lookup shared by the decode stage.
package k_and_s_pkg;

  typedef enum logic [15:0] {
    I_NOP    = 16'h0001,
    I_LOAD   = 16'h0002,
    I_STORE  = 16'h0004,
    I_MOVE   = 16'h0008,
    I_ADD    = 16'h0010,
    I_SUB    = 16'h0020,
    I_AND    = 16'h0040,
    I_OR     = 16'h0080,
    I_BRANCH = 16'h0100,
    I_BZERO  = 16'h0200,
    I_BNZERO = 16'h0400,
    I_BNEG   = 16'h0800,
    I_BNNEG  = 16'h1000,
    I_BOV    = 16'h2000,
    I_BNOV   = 16'h4000,
    I_HALT   = 16'h8000
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h05;
  localparam logic [7:0] OPC_BNOV   = 8'h06;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BNZERO = 8'h0B;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  typedef struct packed {
    logic                    illegal;
    decoded_instruction_type decoded;
  } decode_t;

  // Unknown opcodes decode as NOP with the illegal flag raised.
  function automatic decode_t opcode_to_decoded(input logic [7:0] opc);
    decode_t d;
    d.illegal = 1'b0;
    d.decoded = I_NOP;
    case (opc)
      OPC_NOP:    d.decoded = I_NOP;
      OPC_BRANCH: d.decoded = I_BRANCH;
      OPC_BZERO:  d.decoded = I_BZERO;
      OPC_BNEG:   d.decoded = I_BNEG;
      OPC_BOV:    d.decoded = I_BOV;
      OPC_BNOV:   d.decoded = I_BNOV;
      OPC_BNNEG:  d.decoded = I_BNNEG;
      OPC_BNZERO: d.decoded = I_BNZERO;
      OPC_LOAD:   d.decoded = I_LOAD;
      OPC_STORE:  d.decoded = I_STORE;
      OPC_MOVE:   d.decoded = I_MOVE;
      OPC_ADD:    d.decoded = I_ADD;
      OPC_SUB:    d.decoded = I_SUB;
      OPC_AND:    d.decoded = I_AND;
      OPC_OR:     d.decoded = I_OR;
      OPC_HALT:   d.decoded = I_HALT;
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/k_and_s_decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage; the stage
// itself connects through the slave modport.
interface k_and_s_decode_stage_if #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 2,
  parameter int ADDR_W  = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_decoded;
  logic [REG_AW-1:0]  out_ra;
  logic [REG_AW-1:0]  out_rb;
  logic [REG_AW-1:0]  out_rc;
  logic [ADDR_W-1:0]  out_addr;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_decoded, out_ra, out_rb, out_rc,
           out_addr, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_decoded, out_ra, out_rb, out_rc,
           out_addr, out_illegal
  );
endinterface

// File: rtl/k_and_s_decode_stage.sv
// K&S instruction decode stage: one-deep elastic register holding the one-hot
// decode and operand fields, with flush, sticky HALT/resume and retire counter.
module k_and_s_decode_stage
  import k_and_s_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 8,
  parameter int REG_AW  = 2,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  k_and_s_decode_stage_if.slave bus,
  input  logic                 flush,
  input  logic                 resume,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  logic [OPC_W-1:0]        opc_p0;
  decode_t                 dec_p0;
  logic                    accept;
  logic                    retire;
  logic                    unused_instr;

  logic                    vld_p1;
  logic                    illegal_p1;
  decoded_instruction_type decoded_p1;
  logic [REG_AW-1:0]       ra_p1;
  logic [REG_AW-1:0]       rb_p1;
  logic [REG_AW-1:0]       rc_p1;
  logic [ADDR_W-1:0]       addr_p1;

  // p0: combinational decode of the presented word
  assign opc_p0       = bus.in_instr[INSTR_W-1 -: OPC_W];
  assign dec_p0       = opcode_to_decoded(8'(opc_p0));
  assign unused_instr = ^bus.in_instr;

  assign bus.in_ready = !halted && !flush && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // A flushed entry leaves without retiring.
  assign retire       = vld_p1 && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      if (flush)       vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (retire) vld_p1 <= 1'b0;

      if (retire && instr_count != {CNT_W{1'b1}})
        instr_count <= instr_count + 1'b1;

      if (retire && decoded_p1 == I_HALT) halted <= 1'b1;
      else if (resume)                    halted <= 1'b0;
    end
  end

  // p1: registered entry, only reloaded on acceptance so it holds under stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_p1 <= 1'b0;
      decoded_p1 <= I_NOP;
      ra_p1      <= '0;
      rb_p1      <= '0;
      rc_p1      <= '0;
      addr_p1    <= '0;
    end else if (accept) begin
      illegal_p1 <= dec_p0.illegal;
      decoded_p1 <= dec_p0.decoded;
      rc_p1      <= bus.in_instr[REG_AW-1:0];
      rb_p1      <= bus.in_instr[2*REG_AW-1:REG_AW];
      ra_p1      <= bus.in_instr[3*REG_AW-1:2*REG_AW];
      addr_p1    <= bus.in_instr[ADDR_W-1:0];
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_decoded = decoded_p1;
  assign bus.out_illegal = illegal_p1;
  assign bus.out_ra      = ra_p1;
  assign bus.out_rb      = rb_p1;
  assign bus.out_rc      = rc_p1;
  assign bus.out_addr    = addr_p1;

endmodule

// File: tb/tb_k_and_s_decode_stage.sv
// Bench for k_and_s_decode_stage: vector table plus hand sequences, entries
// checked against a scoreboard queue; a CNT_W=3 twin checks saturation.
module tb_k_and_s_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        resume;
  logic        halted;
  logic        halted2;
  logic [15:0] cnt;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  k_and_s_decode_stage_if #(.INSTR_W(16), .REG_AW(2), .ADDR_W(5)) bus ();
  k_and_s_decode_stage_if #(.INSTR_W(16), .REG_AW(2), .ADDR_W(5)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.out_ready = bus.out_ready;

  k_and_s_decode_stage #(.INSTR_W(16), .OPC_W(8), .REG_AW(2), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .resume(resume),
    .halted(halted), .instr_count(cnt)
  );

  k_and_s_decode_stage #(.INSTR_W(16), .OPC_W(8), .REG_AW(2), .ADDR_W(5), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush), .resume(resume),
    .halted(halted2), .instr_count(cnt2)
  );

  typedef struct {
    logic [15:0] dec;
    logic        ill;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [1:0]  rc;
    logic [4:0]  addr;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] dec;
    logic        ill;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[18];
  int   n_vec = 0;
  int   n_err = 0;
  logic m_vld, m_halted;
  int   m_cnt, m_cnt2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; resume = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 16'hA11B; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    exp_q.delete();
    m_vld = 1'b0; m_halted = 1'b0; m_cnt = 0; m_cnt2 = 0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_decoded", 32'(bus.out_decoded), 32'h0001);
    chk("rst out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst fields", 32'({bus.out_ra, bus.out_rb, bus.out_rc, bus.out_addr}), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst instr_count", 32'(cnt), 32'd0);
    chk("rst instr_count_sat", 32'(cnt2), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One clock: drive, check combinational/held outputs, update model, check state.
  task automatic tick(input logic v, input logic [15:0] ins, input logic [15:0] edec,
                      input logic eill, input logic ordy, input logic fl, input logic rs);
    exp_t e, h;
    logic rdy, acc, ret, halt_now;
    bus.in_valid = v; bus.in_instr = ins; bus.out_ready = ordy;
    flush = fl; resume = rs;
    #1;
    rdy = !m_halted && !fl && (!m_vld || ordy);
    acc = v && rdy;
    ret = m_vld && ordy && !fl;
    halt_now = 1'b0;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
    if (m_vld && exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_decoded", 32'(bus.out_decoded), 32'(h.dec));
      chk("out_illegal", 32'(bus.out_illegal), 32'(h.ill));
      chk("out_ra", 32'(bus.out_ra), 32'(h.ra));
      chk("out_rb", 32'(bus.out_rb), 32'(h.rb));
      chk("out_rc", 32'(bus.out_rc), 32'(h.rc));
      chk("out_addr", 32'(bus.out_addr), 32'(h.addr));
    end
    if (fl) begin
      if (m_vld && exp_q.size() > 0) void'(exp_q.pop_front());
      m_vld = 1'b0;
    end else begin
      if (ret && exp_q.size() > 0) begin
        h = exp_q.pop_front();
        halt_now = (h.dec == 16'h8000);
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 7) m_cnt2++;
        m_vld = 1'b0;
      end
      if (acc) begin
        e.dec = edec; e.ill = eill;
        e.ra = ins[5:4]; e.rb = ins[3:2]; e.rc = ins[1:0]; e.addr = ins[4:0];
        exp_q.push_back(e);
        m_vld = 1'b1;
      end
    end
    if (halt_now) m_halted = 1'b1;
    else if (rs)  m_halted = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("halted", 32'(halted), 32'(m_halted));
    chk("instr_count", 32'(cnt), 32'(m_cnt));
    chk("instr_count_sat", 32'(cnt2), 32'(m_cnt2));
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 16'h0001, 1'b0};
    vecs[1]  = '{16'h8107, 16'h0002, 1'b0};
    vecs[2]  = '{16'h8213, 16'h0004, 1'b0};
    vecs[3]  = '{16'h911E, 16'h0008, 1'b0};
    vecs[4]  = '{16'hA13F, 16'h0010, 1'b0};
    vecs[5]  = '{16'hA224, 16'h0020, 1'b0};
    vecs[6]  = '{16'hA32A, 16'h0040, 1'b0};
    vecs[7]  = '{16'hA415, 16'h0080, 1'b0};
    vecs[8]  = '{16'h0109, 16'h0100, 1'b0};
    vecs[9]  = '{16'h020C, 16'h0200, 1'b0};
    vecs[10] = '{16'h0B11, 16'h0400, 1'b0};
    vecs[11] = '{16'h0316, 16'h0800, 1'b0};
    vecs[12] = '{16'h0A1F, 16'h1000, 1'b0};
    vecs[13] = '{16'h0502, 16'h2000, 1'b0};
    vecs[14] = '{16'h0603, 16'h4000, 1'b0};
    vecs[15] = '{16'h0400, 16'h0001, 1'b1};
    vecs[16] = '{16'h8000, 16'h0001, 1'b1};
    vecs[17] = '{16'hFEFF, 16'h0001, 1'b1};

    rst_n = 1'b0; flush = 1'b0; resume = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    m_vld = 1'b0; m_halted = 1'b0; m_cnt = 0; m_cnt2 = 0;

    do_reset();

    // streaming ADD then LOAD at one per cycle
    tick(1'b1, 16'hA11B, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h8105, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // illegal opcode under backpressure, word held upstream
    tick(1'b1, 16'h7700, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      tick(1'b1, 16'h7700, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // flush of a held entry while downstream is ready
    tick(1'b1, 16'hA22D, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'hA11B, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // full opcode table, streamed back to back
    for (int i = 0; i < 18; i++)
      tick(1'b1, vecs[i].instr, vecs[i].dec, vecs[i].ill, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("saturated count", 32'(cnt2), 32'd7);

    // HALT retires, following NOP is refused until resume
    tick(1'b1, 16'hFF00, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // HALT retire coinciding with resume: halt wins
    tick(1'b1, 16'hFF3C, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 16'h9109, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset in the middle of a stalled handshake
    tick(1'b1, 16'hA31B, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    tick(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
